// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg: shared types for the UART receive FIFO.
// Holds the fetch FSM state type, the entry width and the stored entry layout.
package rx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam int ENTRY_W = 9;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// fifo_mem: DEPTH x ENTRY_W register array, one synchronous write port and
// one asynchronous read port. No reset; contents are don't-care until written.
module fifo_mem
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  rx_entry_t         wdata,
    input  logic [ADDR_W-1:0] raddr,
    output rx_entry_t         rdata
);

    rx_entry_t mem [DEPTH];

    // Write the addressed entry on the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: drains the UART receiver through its data_ready/data_read handshake
// into a DEPTH-entry show-ahead FIFO of {framing_error, byte} entries.
// Optional build macro RX_FIFO_ERR_DROP_EN: framing-error bytes are acknowledged
// but discarded and counted (saturating) in err_drop_cnt instead of stored.
module rx_fifo
    import rx_fifo_pkg::*;
#(
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_ready,
    input  logic [7:0]        rx_data,
    input  logic              framing_error,
    input  logic              overrun_error,
    output logic              data_read,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_err,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ovr_seen,
    output logic [7:0]        err_drop_cnt
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_q, count_d;
    logic              capture, store, pop;
    rx_entry_t         wr_entry, head;

    // Flags come from the registered count, so a pop never frees a slot for
    // a push in the same cycle.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;

    // A byte is taken only from IDLE with room; the receiver otherwise holds it.
    assign capture = (state_q == IDLE) && data_ready && !full;
    assign pop     = rd_en && !empty;

`ifdef RX_FIFO_ERR_DROP_EN
    // Error bytes are acknowledged but never reach storage.
    assign store = capture && !framing_error;
`else
    assign store = capture;
`endif

    assign wr_entry = '{err: framing_error, data: rx_data};

    fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Show-ahead head entry, forced quiet when nothing is held.
    assign rd_data = empty ? 8'h00 : head.data;
    assign rd_err  = empty ? 1'b0  : head.err;

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch FSM next state: IDLE -> ACK on capture, then one WAIT cycle so
    // the receiver's data_ready has time to fall before we look again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = ACK;
            ACK:     state_d = WAIT;
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered acknowledge: high for exactly the cycle spent in ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_read <= 1'b0;
        end else begin
            data_read <= (state_d == ACK);
        end
    end

    // Occupancy follows pushes minus pops; simultaneous push and pop cancel.
    always_comb begin
        count_d = count_q;
        case ({store, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
            count_q <= count_d;
        end
    end

    // Sticky record that the receiver reported an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_seen <= 1'b0;
        end else if (overrun_error) begin
            ovr_seen <= 1'b1;
        end
    end

`ifdef RX_FIFO_ERR_DROP_EN
    // Count discarded error bytes, holding at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_drop_cnt <= 8'd0;
        end else if (capture && framing_error && err_drop_cnt != 8'hFF) begin
            err_drop_cnt <= err_drop_cnt + 8'd1;
        end
    end
`else
    assign err_drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: table vectors, hand-written corner sequences and a randomized
// run against a queue-based reference model of the receive FIFO.
module tb_rx_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);
`ifdef RX_FIFO_ERR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_ready = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          framing_error = 1'b0;
    logic          overrun_error = 1'b0;
    logic          rd_en = 1'b0;
    logic          data_read, rd_err, empty, full, ovr_seen;
    logic [7:0]    rd_data, err_drop_cnt;
    logic [AW:0]   count;

    int vectors     = 0;
    int miscompares = 0;

    rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_ready    (data_ready),
        .rx_data       (rx_data),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .data_read     (data_read),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_err        (rd_err),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .ovr_seen      (ovr_seen),
        .err_drop_cnt  (err_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rd_en;
        logic       dr;
        logic [7:0] d;
        logic       fe;
        logic       ovr;
        logic       exp_dread;
        logic [3:0] exp_cnt;
        logic [7:0] exp_data;
        logic       exp_err;
        logic       exp_ovr;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_ready = 1'b0;
        framing_error = 1'b0;
        overrun_error = 1'b0;
        rd_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Behave like the receiver: hold data_ready until the acknowledge appears,
    // then drop it and let the fetch side return to idle.
    task automatic send(input logic [7:0] b, input logic fe);
        int n;
        n = 0;
        data_ready = 1'b1;
        rx_data = b;
        framing_error = fe;
        do begin
            tick();
            n++;
        end while (!data_read && n < 30);
        chk("send_ack", 32'(data_read), 32'd1);
        data_ready = 1'b0;
        framing_error = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [8:0] q[$];
        logic [7:0] pb;
        logic       pf, pend, mcap, mpop, seen;
        int         busy, mdrop, n;

        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_data_read", 32'(data_read), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovr", 32'(ovr_seen), 32'd0);
        chk("rst_drop", 32'(err_drop_cnt), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);

        // Single byte through the handshake, pops, empty pop, overrun pulse.
        tbl[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 4'd1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd1, 8'hA5, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1, 8'hA5, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            rd_en = tbl[i].rd_en;
            data_ready = tbl[i].dr;
            rx_data = tbl[i].d;
            framing_error = tbl[i].fe;
            overrun_error = tbl[i].ovr;
            tick();
            chk($sformatf("tbl%0d_data_read", i), 32'(data_read), 32'(tbl[i].exp_dread));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_rd_err", i), 32'(rd_err), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_ovr", i), 32'(ovr_seen), 32'(tbl[i].exp_ovr));
        end
        overrun_error = 1'b0;
        rd_en = 1'b0;
        repeat (10) tick();
        chk("ovr_sticky", 32'(ovr_seen), 32'd1);

        // Reset while the acknowledge is being driven.
        data_ready = 1'b1;
        rx_data = 8'h11;
        tick();
        chk("pre_rst_ack", 32'(data_read), 32'd1);
        rst = 1'b1;
        data_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk("midack_data_read", 32'(data_read), 32'd0);
        chk("midack_count", 32'(count), 32'd0);
        chk("midack_empty", 32'(empty), 32'd1);
        chk("midack_ovr_clr", 32'(ovr_seen), 32'd0);

        // Fill, blocked ninth byte, then pop to let it in.
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_head", 32'(rd_data), 32'h01);
        data_ready = 1'b1;
        rx_data = 8'h09;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (data_read) seen = 1'b1;
        end
        chk("full_no_ack", 32'(seen), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pop_no_same_cycle_push", 32'(count), 32'd7);
        n = 0;
        while (!data_read && n < 10) begin
            tick();
            n++;
        end
        chk("ninth_ack", 32'(data_read), 32'd1);
        data_ready = 1'b0;
        tick();
        tick();
        chk("ninth_count", 32'(count), 32'd8);
        chk("ninth_head", 32'(rd_data), 32'h02);

        // Drain to three entries (07,08,09), then push and pop together.
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("drain_head%0d", k), 32'(rd_data), 32'(k + 2));
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("drain_count", 32'(count), 32'd3);
        data_ready = 1'b1;
        rx_data = 8'h0A;
        rd_en = 1'b1;
        tick();
        chk("pushpop_ack", 32'(data_read), 32'd1);
        chk("pushpop_count", 32'(count), 32'd3);
        chk("pushpop_head", 32'(rd_data), 32'h08);
        rd_en = 1'b0;
        data_ready = 1'b0;
        tick();
        tick();
        // 0x09 and 0x0A sit past the wrap of index 7.
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wrap_head%0d", k), 32'(rd_data), 32'(k + 8));
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_rd_data", 32'(rd_data), 32'd0);

        // Framing-error byte.
        do_reset();
        send(8'h3C, 1'b1);
`ifdef RX_FIFO_ERR_DROP_EN
        chk("errdrop_count", 32'(count), 32'd0);
        chk("errdrop_empty", 32'(empty), 32'd1);
        chk("errdrop_cnt1", 32'(err_drop_cnt), 32'd1);
        repeat (299) send(8'h3C, 1'b1);
        chk("errdrop_sat", 32'(err_drop_cnt), 32'd255);
        chk("errdrop_count_after", 32'(count), 32'd0);
`else
        chk("errbyte_count", 32'(count), 32'd1);
        chk("errbyte_data", 32'(rd_data), 32'h3C);
        chk("errbyte_err", 32'(rd_err), 32'd1);
        chk("errbyte_dropcnt", 32'(err_drop_cnt), 32'd0);
`endif

        // Randomized traffic against a queue model of the FIFO.
        do_reset();
        busy = 0;
        pend = 1'b0;
        pb = 8'h00;
        pf = 1'b0;
        mdrop = 0;
        for (int i = 0; i < 3000; i++) begin
            chk("rnd_data_read", 32'(data_read), 32'(busy == 2));
            chk("rnd_count", 32'(count), 32'(q.size()));
            chk("rnd_empty", 32'(empty), 32'(q.size() == 0));
            chk("rnd_full", 32'(full), 32'(q.size() == DEPTH));
            chk("rnd_rd_data", 32'(rd_data), 32'(q.size() > 0 ? q[0][7:0] : 8'h00));
            chk("rnd_rd_err", 32'(rd_err), 32'(q.size() > 0 ? q[0][8] : 1'b0));
            chk("rnd_drop", 32'(err_drop_cnt), 32'(mdrop));
            if (pend && data_read) pend = 1'b0;
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1'b1;
                pb = 8'($urandom);
                pf = ($urandom_range(0, 7) == 0);
            end
            data_ready = pend;
            rx_data = pb;
            framing_error = pf;
            rd_en = ($urandom_range(0, 99) < (i < 1500 ? 12 : 45));
            mcap = (busy == 0) && pend && (q.size() < DEPTH);
            mpop = rd_en && (q.size() > 0);
            if (mpop) void'(q.pop_front());
            if (mcap) begin
                if (DROP && pf) begin
                    if (mdrop < 255) mdrop++;
                end else begin
                    q.push_back({pf, pb});
                end
            end
            busy = mcap ? 2 : (busy > 0 ? busy - 1 : 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
